acl2_spi_responder: RTL and testbench
=====================================

Name: acl2_spi_responder

Overview:
SPI mode-0 slave model of the ACL2 (ADXL362-style) accelerometer register interface. It is the responder end of the accelerometer SPI link: it decodes write-register (0x0A) and read-register (0x0B) commands, serves a 64-byte register map, and presents X/Y/Z samples supplied by the bench or a stimulus source. It raises a data-ready interrupt. It is used for closed-loop simulation and hardware-in-loop testing of the accelerometer master without the physical sensor.

Parameters:
DEVID_AD, 8'hAD, value returned at address 0x00
DEVID_MST, 8'h1D, value returned at address 0x01
PARTID, 8'hF2, value returned at address 0x02
SYNC_STAGES, 2, synchroniser depth on sclk/mosi/chip_select (>=2)

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, idle low
mosi  input  1  SPI data from master
chip_select  input  1  active-low SPI select
miso  output  1  SPI data to master
miso_oe  output  1  high while chip_select is low (synchronised)
sample_valid  input  1  one-cycle pulse: x_in/y_in/z_in hold a new sample
x_in  input  16  X sample, two's complement
y_in  input  16  Y sample
z_in  input  16  Z sample
int1  output  1  data-ready interrupt, active high
power_ctl  output  8  current contents of register 0x2D
reg_wr  output  1  one-cycle pulse on each completed register write byte
reg_wr_addr  output  6  address of that write
reg_wr_data  output  8  data of that write

Behaviour:
- Reset (rst=0, async): all sync flops are 0, except chip_select syncs, which are 1. FSM=IDLE; miso=0; miso_oe=0; int1=0; reg_wr=0; reg_wr_addr=0; reg_wr_data=0. Writable registers are 0, so power_ctl=0. Sample registers are 0 and pending flag=0.
- Inputs sclk, mosi and chip_select pass through SYNC_STAGES flops. Rising and falling edges of sclk are detected on the synchronised copy. All actions occur one clk after the detected edge.
- SPI mode 0. The responder shifts mosi in MSB-first on sclk rising edges. It updates miso on sclk falling edges. A 3-bit bit counter resets on chip_select falling.
- FSM states:
  - IDLE: go to CMD on chip_select falling.
  - CMD: after 8 bits, go to ADDR if the byte is 0x0A or 0x0B; otherwise go to IGNORE.
  - ADDR: after 8 bits, load the address pointer from bits [5:0]; bits [7:6] are ignored. Go to WR for 0x0A or RD for 0x0B.
  - WR: after each 8 bits, store the byte to the pointer address if that address is writable. Pulse reg_wr with the address and data for every byte, writable or not. Then increment the pointer.
  - RD: on loading the pointer and after each completed byte, load the shift-out register with reg[pointer], then increment the pointer.
  - IGNORE: miso is held 0 until the transaction ends.
- Any state returns to IDLE on chip_select rising, even mid-byte. A partial byte is discarded with no write and no reg_wr.
- miso in RD: the MSB of the loaded byte is driven within 1 clk of the load. Each sclk falling edge shifts the next bit out. miso=0 outside RD.
- Address pointer is 6 bits and wraps 0x3F→0x00.
- Register map:
  - 0x00–0x02: DEVID_AD, DEVID_MST, PARTID; read-only.
  - 0x0B: STATUS, where bit0 = data-ready; read-only.
  - 0x0E–0x13: XL, XH, YL, YH, ZL, ZH; read-only.
  - 0x1F–0x2E: 16 writable bytes.
  - All other addresses: read 0x00, writes dropped.
- Sample capture:
  - If sample_valid arrives while idle (synchronised chip_select high), X/Y/Z registers load on the next clk.
  - If it arrives while chip_select is low, the sample is held in a pending buffer. It loads 1 clk after chip_select rises. A newer pulse overwrites the pending sample.
  - Captured registers never change during a transaction, so multi-byte reads are coherent.
- Data-ready:
  - Set on any sample load when power_ctl[1:0]==2'b10 (measurement mode).
  - Cleared at transaction end if any RD byte read an address in 0x0E–0x13.
  - If clear and set fall on the same clk, set wins.
  - int1 equals data-ready.
- Writing 0x00 to 0x2D does not clear an already-set data-ready.

Test Plan:
- Reset check: rst low → miso=0, int1=0, power_ctl=0. Read cmd 0x0B addr 0x00 for 3 bytes → 0xAD, 0x1D, 0xF2.
- Write 0x0A, 0x2D, 0x02 → power_ctl=0x02; one reg_wr pulse with addr 0x2D and data 0x02. Then read 0x2D → 0x02.
- With power_ctl=0x02, pulse sample_valid with x=0x1234, y=0xFFF0, z=0x0100 → int1=1. Burst read from 0x0E, 6 bytes → 34 12 F0 FF 00 01. After chip_select rises, int1=0.
- Pulse sample_valid (x=0x0001) mid-burst read of 0x0E → bytes return the old sample. After chip_select rises, XL=0x01 and int1=1.
- Burst read starting at 0x3F for 2 bytes → reg[0x3F]=0x00 then 0xAD (wrap). Command 0x55 → miso stays 0 and no reg_wr.
- Deassert chip_select after 4 data bits of a write to 0x20 → 0x20 unchanged and no reg_wr. Assert rst mid-read → all outputs return to their reset values at once.

Source files
------------

// File: rtl/acl2_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : acl2_spi_responder
// Purpose  : SPI mode-0 responder emulating the ACL2 (ADXL362-style)
//            accelerometer register interface. Decodes write (0x0A) and read
//            (0x0B) commands, serves a 64-byte register map, holds coherent
//            X/Y/Z samples and raises a data-ready interrupt.
// Ports    : clk, rst (async, active-low)
//            sclk, mosi, chip_select  - SPI inputs from master (synchronised)
//            miso, miso_oe            - SPI data back to master
//            sample_valid, x_in/y_in/z_in - sample source interface
//            int1                     - data-ready interrupt
//            power_ctl                - contents of register 0x2D
//            reg_wr/_addr/_data       - pulse per completed write byte
// Revision : 1.0 - initial release
// ============================================================================
module acl2_spi_responder #(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        chip_select,
    output logic        miso,
    output logic        miso_oe,
    input  logic        sample_valid,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    output logic        int1,
    output logic [7:0]  power_ctl,
    output logic        reg_wr,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WR     = 3'd3,
        ST_RD     = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    state_t r_state, w_next_state;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic r_sclk_prev, r_cs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk, w_mosi, w_cs;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_rise   = w_cs & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift_in;
    logic [7:0]  r_shift_out;
    logic [5:0]  r_ptr;
    logic        r_is_read;
    logic [7:0]  r_regs [0:15];          // writable bytes 0x1F..0x2E
    logic [15:0] r_x, r_y, r_z;
    logic [15:0] r_pend_x, r_pend_y, r_pend_z;
    logic        r_pend_valid;
    logic        r_data_ready;
    logic        r_read_sample;

    logic       w_active, w_byte_done;
    logic [7:0] w_rx_byte;
    assign w_active    = (r_state != ST_IDLE) && !w_cs;
    assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_shift_in, w_mosi};

    // Read mux: the ADDR state loads straight from the incoming address byte.
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [3:0] w_rd_idx, w_wr_idx;
    logic       w_rd_is_sample, w_wr_ok;
    assign w_rd_addr = (r_state == ST_ADDR) ? w_rx_byte[5:0] : r_ptr;
    // Offset from 0x1F modulo 16 needs only the low nibble.
    assign w_rd_idx  = w_rd_addr[3:0] - 4'hF;
    assign w_wr_idx  = r_ptr[3:0] - 4'hF;
    assign w_rd_is_sample = (w_rd_addr >= 6'h0E) && (w_rd_addr <= 6'h13);
    assign w_wr_ok        = (r_ptr >= 6'h1F) && (r_ptr <= 6'h2E);

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            6'h00:   w_rd_data = DEVID_AD;
            6'h01:   w_rd_data = DEVID_MST;
            6'h02:   w_rd_data = PARTID;
            6'h0B:   w_rd_data = {7'b0, r_data_ready};
            6'h0E:   w_rd_data = r_x[7:0];
            6'h0F:   w_rd_data = r_x[15:8];
            6'h10:   w_rd_data = r_y[7:0];
            6'h11:   w_rd_data = r_y[15:8];
            6'h12:   w_rd_data = r_z[7:0];
            6'h13:   w_rd_data = r_z[15:8];
            default: begin
                if ((w_rd_addr >= 6'h1F) && (w_rd_addr <= 6'h2E))
                    w_rd_data = r_regs[w_rd_idx];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_cs_rise) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_next_state = ST_CMD;
                ST_CMD: begin
                    if (w_byte_done)
                        w_next_state = ((w_rx_byte == 8'h0A) || (w_rx_byte == 8'h0B))
                                       ? ST_ADDR : ST_IGNORE;
                end
                ST_ADDR: if (w_byte_done) w_next_state = r_is_read ? ST_RD : ST_WR;
                default: w_next_state = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Samples: loaded directly while deselected, otherwise deferred.
    // ------------------------------------------------------------------
    logic w_load_direct, w_load_pend, w_load, w_measure;
    assign w_load_direct = sample_valid && w_cs;
    assign w_load_pend   = w_cs_rise && r_pend_valid && !sample_valid;
    assign w_load        = w_load_direct || w_load_pend;
    assign w_measure     = (r_regs[14][1:0] == 2'b10);   // register 0x2D

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt     <= 3'd0;
            r_shift_in    <= 7'd0;
            r_shift_out   <= 8'd0;
            r_ptr         <= 6'd0;
            r_is_read     <= 1'b0;
            reg_wr        <= 1'b0;
            reg_wr_addr   <= 6'd0;
            reg_wr_data   <= 8'd0;
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'd0;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_z           <= 16'd0;
            r_pend_x      <= 16'd0;
            r_pend_y      <= 16'd0;
            r_pend_z      <= 16'd0;
            r_pend_valid  <= 1'b0;
            r_data_ready  <= 1'b0;
            r_read_sample <= 1'b0;
        end else begin
            reg_wr <= 1'b0;

            if (w_cs_fall) begin
                r_bit_cnt     <= 3'd0;
                r_read_sample <= 1'b0;
            end else if (w_active && w_sclk_rise) begin
                r_shift_in <= w_rx_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end

            // No shift on the falling edge that follows a byte boundary:
            // the freshly loaded MSB must survive until the next rising edge.
            if (w_active && w_sclk_fall && (r_state == ST_RD) && (r_bit_cnt != 3'd0))
                r_shift_out <= {r_shift_out[6:0], 1'b0};

            if (w_byte_done) begin
                case (r_state)
                    ST_CMD: r_is_read <= (w_rx_byte == 8'h0B);
                    ST_ADDR: begin
                        if (r_is_read) begin
                            r_shift_out <= w_rd_data;
                            r_ptr       <= w_rx_byte[5:0] + 6'd1;
                            if (w_rd_is_sample) r_read_sample <= 1'b1;
                        end else begin
                            r_ptr <= w_rx_byte[5:0];
                        end
                    end
                    ST_WR: begin
                        reg_wr      <= 1'b1;
                        reg_wr_addr <= r_ptr;
                        reg_wr_data <= w_rx_byte;
                        if (w_wr_ok) r_regs[w_wr_idx] <= w_rx_byte;
                        r_ptr <= r_ptr + 6'd1;
                    end
                    ST_RD: begin
                        r_shift_out <= w_rd_data;
                        r_ptr       <= r_ptr + 6'd1;
                        if (w_rd_is_sample) r_read_sample <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_load_direct) begin
                r_x <= x_in;
                r_y <= y_in;
                r_z <= z_in;
            end else if (w_load_pend) begin
                r_x <= r_pend_x;
                r_y <= r_pend_y;
                r_z <= r_pend_z;
            end

            if (sample_valid && !w_cs) begin
                r_pend_x     <= x_in;
                r_pend_y     <= y_in;
                r_pend_z     <= z_in;
                r_pend_valid <= 1'b1;
            end else if (w_cs_rise) begin
                r_pend_valid <= 1'b0;
            end

            // Set has priority over the end-of-transaction clear.
            if (w_load && w_measure)
                r_data_ready <= 1'b1;
            else if (w_cs_rise && r_read_sample)
                r_data_ready <= 1'b0;
        end
    end

    assign miso      = (r_state == ST_RD) ? r_shift_out[7] : 1'b0;
    assign miso_oe   = ~w_cs;
    assign int1      = r_data_ready;
    assign power_ctl = r_regs[14];

endmodule
`default_nettype wire

// File: tb/tb_acl2_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_acl2_spi_responder
// Purpose  : Directed self-checking bench for acl2_spi_responder. Drives SPI
//            mode-0 transactions and compares against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acl2_spi_responder;

    localparam int HALF = 8;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        chip_select = 1'b1;
    logic        miso, miso_oe;
    logic        sample_valid = 1'b0;
    logic [15:0] x_in = 16'h0, y_in = 16'h0, z_in = 16'h0;
    logic        int1;
    logic [7:0]  power_ctl;
    logic        reg_wr;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;

    int checks = 0;
    int passes = 0;
    int wr_count = 0;
    int miso_hi = 0;
    logic [5:0] last_addr = 6'h0;
    logic [7:0] last_data = 8'h0;

    acl2_spi_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .chip_select(chip_select),
        .miso(miso), .miso_oe(miso_oe), .sample_valid(sample_valid),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .int1(int1), .power_ctl(power_ctl),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_wr) begin
            wr_count  <= wr_count + 1;
            last_addr <= reg_wr_addr;
            last_data <= reg_wr_data;
        end
        if (miso) miso_hi <= miso_hi + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = tx[i];
            wait_clks(HALF);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low;
        chip_select = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_high;
        wait_clks(HALF);
        chip_select = 1'b1;
        wait_clks(6);
    endtask

    task automatic pulse_sample;
        sample_valid = 1'b1;
        wait_clks(1);
        sample_valid = 1'b0;
        wait_clks(2);
    endtask

    initial begin
        logic [7:0] rx;
        int wc0, mh0;

        // Reset state
        wait_clks(3);
        check("rst_miso", {15'h0, miso}, 16'h0);
        check("rst_miso_oe", {15'h0, miso_oe}, 16'h0);
        check("rst_int1", {15'h0, int1}, 16'h0);
        check("rst_power_ctl", {8'h0, power_ctl}, 16'h0);
        check("rst_reg_wr", {15'h0, reg_wr}, 16'h0);
        rst = 1'b1;
        wait_clks(3);

        // ID registers
        cs_low();
        check("miso_oe_active", {15'h0, miso_oe}, 16'h1);
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx); check("devid_ad", {8'h0, rx}, 16'h00AD);
        spi_byte(8'h00, rx); check("devid_mst", {8'h0, rx}, 16'h001D);
        spi_byte(8'h00, rx); check("partid", {8'h0, rx}, 16'h00F2);
        cs_high();

        // Write POWER_CTL = 0x02
        wc0 = wr_count;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h2D, rx);
        spi_byte(8'h02, rx);
        cs_high();
        check("power_ctl_wr", {8'h0, power_ctl}, 16'h0002);
        check("wr_pulses", wr_count[15:0] - wc0[15:0], 16'd1);
        check("wr_addr", {10'h0, last_addr}, 16'h002D);
        check("wr_data", {8'h0, last_data}, 16'h0002);
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h2D, rx);
        spi_byte(8'h00, rx); check("rd_power_ctl", {8'h0, rx}, 16'h0002);
        cs_high();

        // Sample capture while idle and burst read
        x_in = 16'h1234; y_in = 16'hFFF0; z_in = 16'h0100;
        pulse_sample();
        check("int1_set", {15'h0, int1}, 16'h1);
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h00, rx); check("xl", {8'h0, rx}, 16'h0034);
        spi_byte(8'h00, rx); check("xh", {8'h0, rx}, 16'h0012);
        spi_byte(8'h00, rx); check("yl", {8'h0, rx}, 16'h00F0);
        spi_byte(8'h00, rx); check("yh", {8'h0, rx}, 16'h00FF);
        spi_byte(8'h00, rx); check("zl", {8'h0, rx}, 16'h0000);
        spi_byte(8'h00, rx); check("zh", {8'h0, rx}, 16'h0001);
        cs_high();
        check("int1_cleared", {15'h0, int1}, 16'h0);

        // Sample arriving mid-burst is deferred
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h00, rx); check("coh_xl", {8'h0, rx}, 16'h0034);
        x_in = 16'h0001;
        pulse_sample();
        check("int1_held_mid", {15'h0, int1}, 16'h0);
        spi_byte(8'h00, rx); check("coh_xh", {8'h0, rx}, 16'h0012);
        spi_byte(8'h00, rx); check("coh_yl", {8'h0, rx}, 16'h00F0);
        spi_byte(8'h00, rx); check("coh_yh", {8'h0, rx}, 16'h00FF);
        spi_byte(8'h00, rx); check("coh_zl", {8'h0, rx}, 16'h0000);
        spi_byte(8'h00, rx); check("coh_zh", {8'h0, rx}, 16'h0001);
        cs_high();
        check("int1_set_wins", {15'h0, int1}, 16'h1);
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h00, rx); check("pend_xl", {8'h0, rx}, 16'h0001);
        cs_high();
        check("int1_cleared2", {15'h0, int1}, 16'h0);

        // Pointer wrap
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h3F, rx);
        spi_byte(8'h00, rx); check("wrap_3f", {8'h0, rx}, 16'h0000);
        spi_byte(8'h00, rx); check("wrap_00", {8'h0, rx}, 16'h00AD);
        cs_high();

        // Unknown command is ignored
        wc0 = wr_count; mh0 = miso_hi;
        cs_low();
        spi_byte(8'h55, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        cs_high();
        check("ign_miso", miso_hi[15:0] - mh0[15:0], 16'd0);
        check("ign_reg_wr", wr_count[15:0] - wc0[15:0], 16'd0);

        // Full write then aborted partial write to 0x20
        wc0 = wr_count;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h5A, rx);
        cs_high();
        check("wr20_pulse", wr_count[15:0] - wc0[15:0], 16'd1);
        wc0 = wr_count;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h20, rx);
        spi_bits(8'hF0, 4, rx);
        cs_high();
        check("partial_no_wr", wr_count[15:0] - wc0[15:0], 16'd0);
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h00, rx); check("rd20", {8'h0, rx}, 16'h005A);
        cs_high();
        check("power_ctl_kept", {8'h0, power_ctl}, 16'h0002);

        // Reset mid-read of STATUS
        pulse_sample();
        check("int1_pre_rst", {15'h0, int1}, 16'h1);
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h0B, rx);
        spi_bits(8'h00, 7, rx);
        wait_clks(6);
        check("status_bit0", {15'h0, miso}, 16'h1);
        #1 rst = 1'b0;
        #1;
        check("arst_miso", {15'h0, miso}, 16'h0);
        check("arst_miso_oe", {15'h0, miso_oe}, 16'h0);
        check("arst_int1", {15'h0, int1}, 16'h0);
        check("arst_power_ctl", {8'h0, power_ctl}, 16'h0);
        check("arst_wr_addr", {10'h0, reg_wr_addr}, 16'h0);
        check("arst_wr_data", {8'h0, reg_wr_data}, 16'h0);
        chip_select = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
